dav_arbiter_3: RTL and testbench

Three-to-one arbiter for the dav_/rfd handshake. It collects 8-bit results from three producers, typically three minimum-voltage acquisition units, each with its own dav_/rfd pair. It forwards them one at a time to a single consumer over one dav_/rfd port, tagging each transfer with the source channel number. Producers are served in round-robin order, so no producer can starve another. The arbiter also keeps a running count of completed transfers.

---
 rtl/dav_arbiter_3_pkg.sv | 41 ++++
 rtl/dav_arbiter_3_rr_select_3.sv | 35 +++
 rtl/dav_arbiter_3.sv | 130 +++++++++++++
 tb/tb_dav_arbiter_3.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dav_arbiter_3_pkg.sv
// Shared definitions for the three-channel dav_/rfd arbiter.
package dav_arbiter_3_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StOffer   = 2'd1,
        StHandoff = 2'd2,
        StClose   = 2'd3
    } state_e;

    localparam logic [1:0] Chan0    = 2'd0;
    localparam logic [1:0] Chan1    = 2'd1;
    localparam logic [1:0] Chan2    = 2'd2;
    localparam logic [1:0] PtrReset = Chan2;

    // Successor of a channel in round-robin order (mod 3).
    function automatic logic [1:0] next_chan(input logic [1:0] c);
        logic [1:0] n;
        case (c)
            Chan0:   n = Chan1;
            Chan1:   n = Chan2;
            default: n = Chan0;
        endcase
        return n;
    endfunction

    // One-hot decode of a channel code; code 3 decodes to nothing.
    function automatic logic [2:0] chan_onehot(input logic [1:0] c);
        logic [2:0] oh;
        case (c)
            Chan0:   oh = 3'b001;
            Chan1:   oh = 3'b010;
            Chan2:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dav_arbiter_3_rr_select_3.sv
// Combinational round-robin selector: searches ptr+1, ptr+2, ptr+3 (mod 3).
module rr_select_3
    import dav_arbiter_3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] cand3;

    assign cand1 = next_chan(ptr);
    assign cand2 = next_chan(cand1);
    assign cand3 = next_chan(cand2);

    // First requesting candidate in search order wins.
    always_comb begin
        grant = Chan0;
        valid = 1'b0;
        if (|(req & chan_onehot(cand1))) begin
            grant = cand1;
            valid = 1'b1;
        end else if (|(req & chan_onehot(cand2))) begin
            grant = cand2;
            valid = 1'b1;
        end else if (|(req & chan_onehot(cand3))) begin
            grant = cand3;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/dav_arbiter_3.sv
// Three-to-one round-robin arbiter for the dav_/rfd handshake with transfer counter.
module dav_arbiter_3
    import dav_arbiter_3_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         dav1_,
    input  logic         dav2_,
    input  logic         dav3_,
    input  logic [W-1:0] data1,
    input  logic [W-1:0] data2,
    input  logic [W-1:0] data3,
    output logic         rfd1,
    output logic         rfd2,
    output logic         rfd3,
    input  logic         rfd,
    output logic         dav_,
    output logic [W-1:0] data,
    output logic [1:0]   chan,
    output logic [7:0]   xfer_count
);

    state_e       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [W-1:0] data_q, data_d;
    logic [1:0]   chan_q, chan_d;
    logic         dav_q, dav_d;
    logic [2:0]   rfd_q, rfd_d;
    logic [7:0]   count_q, count_d;

    logic [2:0]   dav_vec;
    logic [2:0]   grant_oh;
    logic [1:0]   grant;
    logic         grant_valid;
    logic [W-1:0] grant_data;

    assign dav_vec  = {dav3_, dav2_, dav1_};
    assign grant_oh = chan_onehot(chan_q);

    rr_select_3 u_rr_select (
        .req   (~dav_vec),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    // Data of the channel the selector currently picks.
    always_comb begin
        case (grant)
            Chan0:   grant_data = data1;
            Chan1:   grant_data = data2;
            default: grant_data = data3;
        endcase
    end

    // Handshake FSM: grant, offer to consumer, ack producer, wait for consumer release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        chan_d  = chan_q;
        dav_d   = dav_q;
        rfd_d   = rfd_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (rfd && grant_valid) begin
                    data_d  = grant_data;
                    chan_d  = grant;
                    dav_d   = 1'b0;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (!rfd) begin
                    dav_d   = 1'b1;
                    rfd_d   = rfd_q & ~grant_oh;
                    state_d = StHandoff;
                end
            end
            StHandoff: begin
                // Producer has withdrawn its datum; the transfer is complete.
                if (|(dav_vec & grant_oh)) begin
                    rfd_d   = rfd_q | grant_oh;
                    ptr_d   = chan_q;
                    count_d = count_q + 8'd1;
                    state_d = StClose;
                end
            end
            StClose: begin
                if (rfd) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= StIdle;
            ptr_q   <= PtrReset;
            data_q  <= '0;
            chan_q  <= Chan0;
            dav_q   <= 1'b1;
            rfd_q   <= 3'b111;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            dav_q   <= dav_d;
            rfd_q   <= rfd_d;
            count_q <= count_d;
        end
    end

    assign dav_       = dav_q;
    assign data       = data_q;
    assign chan       = chan_q;
    assign rfd1       = rfd_q[0];
    assign rfd2       = rfd_q[1];
    assign rfd3       = rfd_q[2];
    assign xfer_count = count_q;

endmodule

// File: tb/tb_dav_arbiter_3.sv
// Scoreboard bench for dav_arbiter_3: producer/consumer models plus offer monitor.
module tb_dav_arbiter_3;

    logic       clock = 1'b0;
    logic       reset_ = 1'b0;
    logic [2:0] dav_v = 3'b111;
    logic [7:0] data_v [3];
    logic       rfd = 1'b1;
    logic       rfd1, rfd2, rfd3;
    logic       dav_;
    logic [7:0] data;
    logic [1:0] chan;
    logic [7:0] xfer_count;

    int         left [3];
    int         sent [3];
    logic [7:0] base [3];
    bit         hold [3];
    bit         stall = 1'b0;
    bit         multi_low = 1'b0;
    logic [9:0] sb [$];
    int         total = 0;
    int         bad = 0;

    always #5 clock = ~clock;

    dav_arbiter_3 #(.W(8)) dut (
        .clock      (clock),
        .reset_     (reset_),
        .dav1_      (dav_v[0]),
        .dav2_      (dav_v[1]),
        .dav3_      (dav_v[2]),
        .data1      (data_v[0]),
        .data2      (data_v[1]),
        .data3      (data_v[2]),
        .rfd1       (rfd1),
        .rfd2       (rfd2),
        .rfd3       (rfd3),
        .rfd        (rfd),
        .dav_       (dav_),
        .data       (data),
        .chan       (chan),
        .xfer_count (xfer_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Producers: lower dav_ when work is left, raise it once rfd_i acknowledges.
    initial begin
        for (int i = 0; i < 3; i++) begin
            left[i] = 0; sent[i] = 0; base[i] = 8'h00; hold[i] = 1'b0; data_v[i] = 8'h00;
        end
        forever begin
            logic [2:0] rv;
            @(negedge clock);
            rv = {rfd3, rfd2, rfd1};
            for (int i = 0; i < 3; i++) begin
                if (!rv[i] && !dav_v[i]) begin
                    if (!hold[i]) dav_v[i] = 1'b1;
                end else if (dav_v[i] && rv[i] && left[i] > 0) begin
                    data_v[i] = base[i] + 8'(sent[i]);
                    dav_v[i]  = 1'b0;
                    sent[i]++;
                    left[i]--;
                end
            end
        end
    end

    // Consumer: take a datum when offered, re-arm once dav_ returns high.
    initial begin
        forever begin
            @(negedge clock);
            if (stall) rfd = 1'b0;
            else if (!dav_ && rfd) rfd = 1'b0;
            else if (dav_ && !rfd) rfd = 1'b1;
        end
    end

    // Monitor: each new offer is compared against the head of the scoreboard.
    initial begin
        logic       prev;
        logic [9:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (reset_ && !dav_ && prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_offer: got chan=%0d data=%0h want no offer", chan, data);
                end else begin
                    exp = sb.pop_front();
                    check("offer_chan", 32'(chan), 32'(exp[9:8]));
                    check("offer_data", 32'(data), 32'(exp[7:0]));
                end
            end
            if ($countones({rfd3, rfd2, rfd1}) < 2) multi_low = 1'b1;
            prev = dav_;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_count(input logic [7:0] target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (xfer_count == target) break;
            @(negedge clock);
        end
        check(name, 32'(xfer_count), 32'(target));
    endtask

    task automatic wait_rfd2_low(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!rfd2) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Asynchronous reset between edges; optionally verify outputs before any clock edge.
    task automatic do_reset(input bit chk);
        @(negedge clock);
        #2 reset_ = 1'b0;
        #1;
        if (chk) begin
            check("rst_dav", 32'(dav_), 32'd1);
            check("rst_rfd", 32'({rfd3, rfd2, rfd1}), 32'h7);
            check("rst_data", 32'(data), 32'h0);
            check("rst_chan", 32'(chan), 32'h0);
            check("rst_count", 32'(xfer_count), 32'h0);
        end
        check("queue_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            left[i] = 0; sent[i] = 0; hold[i] = 1'b0; dav_v[i] = 1'b1;
        end
        stall = 1'b0;
        rfd = 1'b1;
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset(1'b1);

        // Single request on producer 2
        @(negedge clock);
        base[1] = 8'h5A;
        sb.push_back({2'd1, 8'h5A});
        left[1] = 1;
        wait_rfd2_low("single_rfd2_low");
        check("single_others_high", 32'({rfd3, rfd1}), 32'h3);
        wait_count(8'd1, 40, "single_count");
        check("single_rfd2_back", 32'(rfd2), 32'd1);

        // All three at once from reset: order 0, 1, 2
        do_reset(1'b0);
        base[0] = 8'h10; base[1] = 8'h20; base[2] = 8'h30;
        sb.push_back({2'd0, 8'h10});
        sb.push_back({2'd1, 8'h20});
        sb.push_back({2'd2, 8'h30});
        left[0] = 1; left[1] = 1; left[2] = 1;
        wait_count(8'd3, 100, "all3_count");

        // Fairness: producer 1 keeps re-requesting against producer 3
        do_reset(1'b0);
        base[0] = 8'hA0; base[2] = 8'hC0;
        sb.push_back({2'd0, 8'hA0});
        sb.push_back({2'd2, 8'hC0});
        sb.push_back({2'd0, 8'hA1});
        sb.push_back({2'd2, 8'hC1});
        sb.push_back({2'd0, 8'hA2});
        left[0] = 3; left[2] = 2;
        wait_count(8'd5, 150, "fair_count");

        // Consumer stall in IDLE with a pending request
        do_reset(1'b0);
        stall = 1'b1;
        @(negedge clock);
        base[0] = 8'h3C;
        sb.push_back({2'd0, 8'h3C});
        left[0] = 1;
        repeat (6) @(negedge clock);
        check("stall_dav_high", 32'(dav_), 32'd1);
        check("stall_rfd_high", 32'({rfd3, rfd2, rfd1}), 32'h7);
        stall = 1'b0;
        wait_count(8'd1, 40, "stall_count");

        // Reset while in HANDOFF aborts the transfer
        do_reset(1'b0);
        base[0] = 8'h11;
        sb.push_back({2'd0, 8'h11});
        left[0] = 1;
        wait_count(8'd1, 40, "pre_abort_count");
        repeat (2) @(negedge clock);
        hold[1] = 1'b1;
        base[1] = 8'h99;
        sb.push_back({2'd1, 8'h99});
        left[1] = 1;
        wait_rfd2_low("abort_in_handoff");
        do_reset(1'b1);
        base[0] = 8'h40; base[1] = 8'h50; base[2] = 8'h60;
        sb.push_back({2'd0, 8'h40});
        sb.push_back({2'd1, 8'h50});
        sb.push_back({2'd2, 8'h60});
        left[0] = 1; left[1] = 1; left[2] = 1;
        wait_count(8'd3, 100, "post_abort_count");

        // Counter wrap over 256 transfers
        do_reset(1'b0);
        base[2] = 8'h00;
        for (int i = 0; i < 256; i++) sb.push_back({2'd2, 8'(i)});
        left[2] = 256;
        wait_count(8'd255, 3000, "wrap_255");
        wait_count(8'd0, 50, "wrap_0");
        repeat (3) @(negedge clock);
        check("wrap_queue_empty", 32'(sb.size()), 32'd0);
        check("wrap_dav_idle", 32'(dav_), 32'd1);
        check("wrap_rfd_idle", 32'({rfd3, rfd2, rfd1}), 32'h7);

        check("single_rfd_low", 32'(multi_low), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
